// File: rtl/positron_layer_serializer.sv
// Gathers one posit from each upstream positron, then replays the full set
// as a single sow/eow-framed stream for the next layer.
module positron_layer_serializer #(
  parameter int unsigned POSIT_WIDTH = 16,
  parameter int unsigned NB_POSITRON = 10
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NB_POSITRON-1:0]             rts_i,
  output logic [NB_POSITRON-1:0]             rtr_o,
  input  logic [NB_POSITRON*POSIT_WIDTH-1:0] posit_i,
  input  logic                               rtr_i,
  output logic                               rts_o,
  output logic                               sow_o,
  output logic                               eow_o,
  output logic [POSIT_WIDTH-1:0]             posit_o
);

  localparam int unsigned IDX_W = (NB_POSITRON > 1) ? $clog2(NB_POSITRON) : 1;

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t                   state, state_nxt;
  logic [NB_POSITRON-1:0]   captured, captured_nxt;
  logic [NB_POSITRON-1:0]   take;
  logic [IDX_W-1:0]         idx, idx_nxt;
  logic [POSIT_WIDTH-1:0]   buffer [NB_POSITRON];
  logic                     last_idx;

  assign last_idx = (idx == IDX_W'(NB_POSITRON - 1));

  // State, flags and word storage; buffer survives between windows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= COLLECT;
      captured <= '0;
      idx      <= '0;
      for (int i = 0; i < NB_POSITRON; i++) buffer[i] <= '0;
    end else begin
      state    <= state_nxt;
      captured <= captured_nxt;
      idx      <= idx_nxt;
      for (int i = 0; i < NB_POSITRON; i++) begin
        if (take[i]) buffer[i] <= posit_i[i*POSIT_WIDTH +: POSIT_WIDTH];
      end
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt    = state;
    captured_nxt = captured;
    idx_nxt      = idx;
    take         = '0;
    rtr_o        = '0;
    rts_o        = 1'b0;
    sow_o        = 1'b0;
    eow_o        = 1'b0;
    posit_o      = '0;
    case (state)
      COLLECT: begin
        rtr_o        = ~captured;
        take         = rts_i & ~captured;
        captured_nxt = captured | take;
        if (&captured_nxt) begin
          state_nxt = EMIT;
          idx_nxt   = '0;
        end
      end
      EMIT: begin
        rts_o   = 1'b1;
        posit_o = buffer[idx];
        sow_o   = (idx == IDX_W'(0));
        eow_o   = last_idx;
        if (rtr_i) begin
          if (last_idx) begin
            captured_nxt = '0;
            idx_nxt      = '0;
            state_nxt    = COLLECT;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_positron_layer_serializer.sv
// Bench for positron_layer_serializer: directed scenarios plus random traffic,
// every cycle compared against a queue-based window model.
module tb_positron_layer_serializer;

  localparam int unsigned PW = 16;
  localparam int unsigned NB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NB-1:0]     rts_i, rtr_o;
  logic [NB*PW-1:0]  posit_i;
  logic              rtr_i, rts_o, sow_o, eow_o;
  logic [PW-1:0]     posit_o;

  logic              rts1_i, rtr1_o, rtr1_i, rts1_o, sow1_o, eow1_o;
  logic [PW-1:0]     posit1_i, posit1_o;

  positron_layer_serializer #(.POSIT_WIDTH(PW), .NB_POSITRON(NB)) dut4 (
    .clk(clk), .rst_n(rst_n), .rts_i(rts_i), .rtr_o(rtr_o), .posit_i(posit_i),
    .rtr_i(rtr_i), .rts_o(rts_o), .sow_o(sow_o), .eow_o(eow_o), .posit_o(posit_o)
  );

  positron_layer_serializer #(.POSIT_WIDTH(PW), .NB_POSITRON(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rts_i(rts1_i), .rtr_o(rtr1_o), .posit_i(posit1_i),
    .rtr_i(rtr1_i), .rts_o(rts1_o), .sow_o(sow1_o), .eow_o(eow1_o), .posit_o(posit1_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Window model: per-positron held flag/value; a full set turns into a queue of words.
  bit          held [NB];
  logic [PW-1:0] val [NB];
  logic [PW-1:0] q [$];
  int          emitted;

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin held[i] = 1'b0; val[i] = '0; end
    q.delete();
    emitted = 0;
  endtask

  task automatic check_outputs();
    logic [NB-1:0] exp_rtr;
    for (int i = 0; i < NB; i++) exp_rtr[i] = (q.size() == 0) && !held[i];
    check("rtr_o", 64'(rtr_o), 64'(exp_rtr));
    if (q.size() > 0) begin
      check("rts_o", 64'(rts_o), 64'd1);
      check("posit_o", 64'(posit_o), 64'(q[0]));
      check("sow_o", 64'(sow_o), 64'(emitted == 0));
      check("eow_o", 64'(eow_o), 64'(emitted == NB - 1));
    end else begin
      check("rts_o_idle", 64'(rts_o), 64'd0);
      check("posit_o_idle", 64'(posit_o), 64'd0);
      check("sow_o_idle", 64'(sow_o), 64'd0);
      check("eow_o_idle", 64'(eow_o), 64'd0);
    end
  endtask

  task automatic model_advance();
    bit all_held;
    if (!rst_n) begin
      model_reset();
    end else if (q.size() > 0) begin
      if (rtr_i) begin
        void'(q.pop_front());
        emitted++;
        if (q.size() == 0) begin
          for (int i = 0; i < NB; i++) held[i] = 1'b0;
          emitted = 0;
        end
      end
    end else begin
      all_held = 1'b1;
      for (int i = 0; i < NB; i++) begin
        if (rts_i[i] && !held[i]) begin
          held[i] = 1'b1;
          val[i]  = posit_i[i*PW +: PW];
        end
        if (!held[i]) all_held = 1'b0;
      end
      if (all_held) begin
        for (int i = 0; i < NB; i++) q.push_back(val[i]);
        emitted = 0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rts_i = '0; posit_i = '0; rtr_i = 1'b1;
    rts1_i = 1'b0; posit1_i = '0; rtr1_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_rts", 64'(rts_o), 64'd0);
    check("rst_rtr", 64'(rtr_o), 64'hF);
    check("rst_posit", 64'(posit_o), 64'd0);
    check("rst_sow_eow", 64'({sow_o, eow_o}), 64'd0);
    check("rst_rtr1", 64'(rtr1_o), 64'd1);
    @(posedge clk); #1;

    // Single-positron layer: one beat with both framing bits
    rts1_i = 1'b1; posit1_i = 16'h7F00;
    @(posedge clk); #1;
    rts1_i = 1'b0; posit1_i = 16'h0000;
    @(negedge clk);
    check("n1_rts", 64'(rts1_o), 64'd1);
    check("n1_sow", 64'(sow1_o), 64'd1);
    check("n1_eow", 64'(eow1_o), 64'd1);
    check("n1_posit", 64'(posit1_o), 64'h7F00);
    check("n1_rtr_busy", 64'(rtr1_o), 64'd0);
    rtr1_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("n1_rts_after", 64'(rts1_o), 64'd0);
    check("n1_rtr_after", 64'(rtr1_o), 64'd1);
    @(posedge clk); #1;

    // All four at once
    rts_i = 4'hF; posit_i = {16'h4444, 16'h3333, 16'h2222, 16'h1111}; rtr_i = 1'b1;
    cycle();
    rts_i = '0;
    repeat (6) cycle();

    // Staggered arrival 2,0,3,1
    rts_i = 4'b0100; posit_i = {16'hD003, 16'hC002, 16'hB001, 16'hA000}; cycle();
    rts_i = 4'b0001; cycle();
    rts_i = 4'b1000; cycle();
    rts_i = 4'b0010; cycle();
    rts_i = '0;
    repeat (6) cycle();

    // Backpressure on word 1
    rts_i = 4'hF; posit_i = {16'h0444, 16'h0333, 16'h0222, 16'h0111}; cycle();
    rts_i = '0; cycle();
    rtr_i = 1'b0; repeat (3) cycle();
    rtr_i = 1'b1; repeat (5) cycle();

    // Double offer on positron 0
    rts_i = 4'b0001; posit_i = {48'h0, 16'h5555}; cycle();
    posit_i = {16'h6666, 16'h7777, 16'h8888, 16'hAAAA}; rts_i = 4'hF; cycle();
    rts_i = 4'b0001; repeat (6) cycle();
    rts_i = 4'b1110; posit_i = {16'h9999, 16'hBBBB, 16'hCCCC, 16'h0000}; cycle();
    rts_i = '0; repeat (6) cycle();

    // Reset mid-emit after word 1
    rts_i = 4'hF; posit_i = {16'hEEE4, 16'hEEE3, 16'hEEE2, 16'hEEE1}; cycle();
    rts_i = '0; repeat (2) cycle();
    rst_n = 1'b0; cycle();
    rst_n = 1'b1; cycle();
    rts_i = 4'hF; posit_i = {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0}; cycle();
    rts_i = '0; repeat (6) cycle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rts_i   = NB'($urandom);
      posit_i = {$urandom, $urandom};
      rtr_i   = ($urandom_range(0, 3) != 0);
      rst_n   = ($urandom_range(0, 299) != 0);
      cycle();
    end
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
